// File: rtl/prefetch_pkg.sv
// Shared constants and pointer helper for the instruction prefetch queue.
package prefetch_pkg;

  // Legal bus widths, in bytes per fetch
  localparam int BUS8  = 1;
  localparam int BUS16 = 2;

  // Default queue depths for the two CPU flavours
  localparam int DEPTH_8088 = 4;
  localparam int DEPTH_8086 = 6;

  // Advance a circular pointer by 'step' slots. The wrap is an explicit
  // compare against depth-1, so depth need not be a power of two.
  function automatic int ptr_inc(input int ptr, input int step, input int depth);
    int p;
    p = ptr;
    for (int i = 0; i < step; i++) begin
      if (p == depth - 1) p = 0;
      else                p = p + 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/prefetch_ram.sv
// DEPTH x 8 register file: two write ports, one asynchronous read port.
// Contents are intentionally not reset.
module prefetch_ram #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we0,
  input  logic [PTR_W-1:0] wa0,
  input  logic [7:0]       wd0,
  input  logic             we1,
  input  logic [PTR_W-1:0] wa1,
  input  logic [7:0]       wd1,
  input  logic [PTR_W-1:0] ra,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Both write ports may fire together; control guarantees distinct addresses.
  always_ff @(posedge CLK) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rdata = mem[ra];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue between the bus interface and the execution
// unit. BIU pushes 1 or 2 bytes per fetch, EU pops one byte from the head.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int BUS_BYTES = BUS8,
  parameter int DEPTH     = DEPTH_8088,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   flush,
  input  logic                   wrValid,
  input  logic [8*BUS_BYTES-1:0] wrData,
  input  logic                   wrOdd,
  input  logic                   advanceTop,
  output logic [7:0]             prefetchTop,
  output logic                   prefetchEmpty,
  output logic                   prefetchFull,
  output logic [CNT_W-1:0]       queueCount,
  output logic                   overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd, wr, wr_p1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       push_n;
  logic             odd, pop, accept, wr_en;
  logic [7:0]       lo_byte, hi_byte;

  // An odd-address fetch only exists on the 16-bit bus.
  assign odd     = (BUS_BYTES == BUS16) ? wrOdd : 1'b0;
  assign lo_byte = wrData[7:0];
  assign hi_byte = wrData[8*BUS_BYTES-1 -: 8];

  // Push size, pop qualification, space check and next count.
  always_comb begin
    push_n  = (BUS_BYTES == BUS16 && !odd) ? 2'd2 : 2'd1;
    pop     = advanceTop && (cnt != '0);
    // Space check credits the same-cycle pop so a full queue can stream.
    accept  = wrValid && ((int'(cnt) + int'(push_n) - int'(pop)) <= DEPTH);
    wr_en   = accept && !flush && !RESET;
    wr_p1   = PTR_W'(ptr_inc(int'(wr), 1, DEPTH));
    cnt_nxt = cnt + (accept ? CNT_W'(push_n) : '0) - CNT_W'(pop);
  end

  prefetch_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .CLK   (CLK),
    .we0   (wr_en),
    .wa0   (wr),
    .wd0   (odd ? hi_byte : lo_byte),
    .we1   (wr_en && (push_n == 2'd2)),
    .wa1   (wr_p1),
    .wd1   (hi_byte),
    .ra    (rd),
    .rdata (prefetchTop)
  );

  // Pointer/count/overflow state; reset beats flush, flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (accept)             wr       <= PTR_W'(ptr_inc(int'(wr), int'(push_n), DEPTH));
      if (pop)                rd       <= PTR_W'(ptr_inc(int'(rd), 1, DEPTH));
      if (wrValid && !accept) overflow <= 1'b1;
      cnt <= cnt_nxt;
    end
  end

  // Status is decoded from the registered count only.
  assign queueCount    = cnt;
  assign prefetchEmpty = (cnt == '0);
  assign prefetchFull  = int'(cnt) > (DEPTH - BUS_BYTES);

endmodule
